// File: rtl/boot_ctrl_pkg.sv
// Shared definitions for the boot sequencer: state encoding and default image size.
// The checksum state is only reachable when BOOT_CSUM_EN is defined.
package boot_ctrl_pkg;

    localparam int BOOT_CODE_SIZE_DEF = 32;

    typedef enum logic [2:0] {
        BOOT_IDLE    = 3'd0,
        BOOT_LOAD    = 3'd1,
        BOOT_FLUSH   = 3'd2,
        BOOT_CSUM    = 3'd3,
        BOOT_RELEASE = 3'd4,
        BOOT_RUN     = 3'd5,
        BOOT_ERROR   = 3'd6
    } boot_state_e;

    function automatic logic state_is_busy(boot_state_e s);
        return (s == BOOT_LOAD) || (s == BOOT_FLUSH) || (s == BOOT_CSUM) || (s == BOOT_RELEASE);
    endfunction

endpackage

// File: rtl/boot_ctrl_if.sv
// Source stream, I-cache boot port and CPU reset/status bundle of the boot sequencer.
// master = the sequencer, slave = the source/cache/CPU side.
interface boot_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              start;
    logic              src_valid;
    logic [DATA_W-1:0] src_data;
    logic              src_ready;
    logic              boot_up;
    logic [ADDR_W-1:0] boot_addr;
    logic [DATA_W-1:0] boot_datai;
    logic              boot_web;
    logic              cpu_rst_n;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        input  start, src_valid, src_data,
        output src_ready, boot_up, boot_addr, boot_datai, boot_web,
               cpu_rst_n, busy, done, err
    );

    modport slave (
        output start, src_valid, src_data,
        input  src_ready, boot_up, boot_addr, boot_datai, boot_web,
               cpu_rst_n, busy, done, err
    );
endinterface

// File: rtl/boot_ctrl.sv
// Boot sequencer: streams an instruction image into the I-cache boot port, then releases the CPU.
// Define BOOT_CSUM_EN to append a checksum word to the image and verify it before release.
//
// state   | meaning
// IDLE    | waiting for start after reset
// LOAD    | accepting image words, one I-cache write per handshake
// FLUSH   | last write retires, cache still in boot mode
// CSUM    | waiting for the checksum word (BOOT_CSUM_EN only)
// RELEASE | leave boot mode, flag done
// RUN     | CPU out of reset; start restarts a boot
// ERROR   | checksum mismatch, CPU held in reset; start restarts a boot
module boot_ctrl
    import boot_ctrl_pkg::*;
#(
    parameter int BOOT_CODE_SIZE = BOOT_CODE_SIZE_DEF,
    parameter int ADDR_W         = 8,
    parameter int DATA_W         = 32
) (
    input  logic        clk,
    input  logic        rst,
    boot_ctrl_if.master bif
);

    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(BOOT_CODE_SIZE - 1);

    boot_state_e       state_q, state_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic              boot_up_q, boot_up_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] datai_q, datai_d;
    logic              web_q, web_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              done_q, done_d;
    logic              src_ready;
    logic              hs;
`ifdef BOOT_CSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
`endif

`ifdef BOOT_CSUM_EN
    assign src_ready = (state_q == BOOT_LOAD) || (state_q == BOOT_CSUM);
`else
    assign src_ready = (state_q == BOOT_LOAD);
`endif
    assign hs = bif.src_valid & src_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= BOOT_IDLE;
            cnt_q       <= '0;
            boot_up_q   <= 1'b0;
            addr_q      <= '0;
            datai_q     <= '0;
            web_q       <= 1'b1;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef BOOT_CSUM_EN
            sum_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            boot_up_q   <= boot_up_d;
            addr_q      <= addr_d;
            datai_q     <= datai_d;
            web_q       <= web_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            done_q      <= done_d;
`ifdef BOOT_CSUM_EN
            sum_q       <= sum_d;
            err_q       <= err_d;
`endif
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        boot_up_d   = boot_up_q;
        addr_d      = addr_q;
        datai_d     = datai_q;
        web_d       = web_q;
        cpu_rst_n_d = cpu_rst_n_q;
        done_d      = done_q;
`ifdef BOOT_CSUM_EN
        sum_d       = sum_q;
        err_d       = err_q;
`endif
        case (state_q)
            BOOT_IDLE: begin
                if (bif.start) begin
                    state_d   = BOOT_LOAD;
                    cnt_d     = '0;
                    boot_up_d = 1'b1;
`ifdef BOOT_CSUM_EN
                    sum_d     = '0;
`endif
                end
            end
            BOOT_LOAD: begin
                if (hs) begin
                    web_d   = 1'b0;
                    addr_d  = cnt_q[ADDR_W-1:0];
                    datai_d = bif.src_data;
                    cnt_d   = cnt_q + 1'b1;
`ifdef BOOT_CSUM_EN
                    sum_d   = sum_q + bif.src_data;
                    if (cnt_q == LAST_IDX) state_d = BOOT_CSUM;
`else
                    if (cnt_q == LAST_IDX) state_d = BOOT_FLUSH;
`endif
                end else begin
                    web_d = 1'b1;
                end
            end
            BOOT_FLUSH: begin
                web_d   = 1'b1;
                state_d = BOOT_RELEASE;
            end
`ifdef BOOT_CSUM_EN
            BOOT_CSUM: begin
                web_d = 1'b1;
                if (hs) begin
                    if (bif.src_data == sum_q) begin
                        state_d = BOOT_RELEASE;
                    end else begin
                        state_d   = BOOT_ERROR;
                        boot_up_d = 1'b0;
                        err_d     = 1'b1;
                    end
                end
            end
`endif
            BOOT_RELEASE: begin
                boot_up_d = 1'b0;
                addr_d    = '0;
                datai_d   = '0;
                done_d    = 1'b1;
                state_d   = BOOT_RUN;
            end
            BOOT_RUN, BOOT_ERROR: begin
                cpu_rst_n_d = (state_q == BOOT_RUN);
                // Restart drops the CPU back into reset before reloading over the live image.
                if (bif.start) begin
                    state_d     = BOOT_LOAD;
                    cnt_d       = '0;
                    boot_up_d   = 1'b1;
                    web_d       = 1'b1;
                    cpu_rst_n_d = 1'b0;
                    done_d      = 1'b0;
`ifdef BOOT_CSUM_EN
                    sum_d       = '0;
                    err_d       = 1'b0;
`endif
                end
            end
            default: state_d = BOOT_IDLE;
        endcase
    end

    assign bif.src_ready  = src_ready;
    assign bif.boot_up    = boot_up_q;
    assign bif.boot_addr  = addr_q;
    assign bif.boot_datai = datai_q;
    assign bif.boot_web   = web_q;
    assign bif.cpu_rst_n  = cpu_rst_n_q;
    assign bif.busy       = state_is_busy(state_q);
    assign bif.done       = done_q;
`ifdef BOOT_CSUM_EN
    assign bif.err        = err_q;
`else
    assign bif.err        = 1'b0;
`endif

endmodule

// File: tb/tb_boot_ctrl.sv
// Scoreboarded bench for boot_ctrl: expected I-cache writes are queued as words are offered,
// a separate monitor pops them on every boot_web=0 cycle; sequencing edges are checked inline.
module tb_boot_ctrl;

    localparam int SIZE   = 32;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 32;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    wr_t  exp_q[$];
    logic [DATA_W-1:0] img_sum;

    boot_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bif ();

    boot_ctrl #(.BOOT_CODE_SIZE(SIZE), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bif (bif.master)
    );

    always #5 clk = ~clk;

    function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: every cache write must be the oldest word still owed to the cache.
    always @(negedge clk) begin
        if (!rst && bif.boot_web === 1'b0) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {24'd0, bif.boot_addr, bif.boot_datai}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                wr_t w;
                w = exp_q.pop_front();
                check("write_addr", 64'(bif.boot_addr), 64'(w.addr));
                check("write_data", 64'(bif.boot_datai), 64'(w.data));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Pulse start for one cycle; afterwards the boot must be under way with the CPU held.
    task automatic do_start();
        @(negedge clk);
        bif.start = 1'b1;
        @(negedge clk);
        bif.start = 1'b0;
        img_sum = '0;
        check("start_boot_up", 64'(bif.boot_up), 64'd1);
        check("start_busy", 64'(bif.busy), 64'd1);
        check("start_done", 64'(bif.done), 64'd0);
        check("start_cpu_rst_n", 64'(bif.cpu_rst_n), 64'd0);
        check("start_err", 64'(bif.err), 64'd0);
    endtask

    // mode 0: back-to-back, 1: valid toggles, 2: random valid plus stray start pulses.
    // pat 0: data=k, 1: data=k+1, 2: random.
    task automatic load_words(input int mode, input int pat, input int nwords, output int cyc);
        int k;
        logic v;
        logic [DATA_W-1:0] d;
        k = 0;
        cyc = 0;
        while (k < nwords && cyc < 2000) begin
            check("ready_in_load", 64'(bif.src_ready), 64'd1);
            v = (mode == 0) ? 1'b1 : (mode == 1) ? ((cyc % 2) == 0) : 1'($urandom_range(0, 1));
            d = (pat == 0) ? DATA_W'(k) : (pat == 1) ? DATA_W'(k + 1) : DATA_W'($urandom);
            bif.src_valid = v;
            bif.src_data  = d;
            bif.start     = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (v) begin
                exp_q.push_back('{addr: k[ADDR_W-1:0], data: d});
                img_sum = img_sum + d;
                k++;
            end
            @(negedge clk);
            cyc++;
        end
        bif.start = 1'b0;
        check("load_budget", 64'(k), 64'(nwords));
    endtask

    // Called on the negedge just after the last data handshake.
    task automatic finish_image(input bit good_csum);
`ifdef BOOT_CSUM_EN
        int w;
        check("csum_ready", 64'(bif.src_ready), 64'd1);
        bif.src_valid = 1'b1;
        bif.src_data  = good_csum ? img_sum : img_sum + 1;
        @(negedge clk);
        bif.src_valid = 1'b0;
        w = 0;
        while (!bif.done && !bif.err && w < 10) begin
            @(negedge clk);
            w++;
        end
        check("csum_done", 64'(bif.done), 64'(good_csum));
        check("csum_err", 64'(bif.err), 64'(!good_csum));
        check("csum_boot_up", 64'(bif.boot_up), 64'd0);
        check("csum_web", 64'(bif.boot_web), 64'd1);
        @(negedge clk);
        @(negedge clk);
        check("csum_cpu_rst_n", 64'(bif.cpu_rst_n), 64'(good_csum));
`else
        check("no_extra_ready", 64'(bif.src_ready), 64'd0);
        check("flush_busy", 64'(bif.busy), 64'd1);
        bif.src_valid = 1'b1;
        bif.src_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        bif.src_valid = 1'b0;
        check("el1_web", 64'(bif.boot_web), 64'd1);
        check("el1_boot_up", 64'(bif.boot_up), 64'd1);
        check("el1_done", 64'(bif.done), 64'd0);
        @(negedge clk);
        check("el2_boot_up", 64'(bif.boot_up), 64'd0);
        check("el2_done", 64'(bif.done), 64'd1);
        check("el2_cpu_rst_n", 64'(bif.cpu_rst_n), 64'd0);
        check("el2_addr", 64'(bif.boot_addr), 64'd0);
        @(negedge clk);
        check("el3_cpu_rst_n", 64'(bif.cpu_rst_n), 64'd1);
        check("el3_busy", 64'(bif.busy), 64'd0);
        check("err_tied", 64'(bif.err), 64'd0);
`endif
        check("all_writes_seen", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int cyc;
        bif.start     = 1'b0;
        bif.src_valid = 1'b0;
        bif.src_data  = '0;
        img_sum       = '0;
        repeat (3) @(negedge clk);
        check("rst_boot_up", 64'(bif.boot_up), 64'd0);
        check("rst_web", 64'(bif.boot_web), 64'd1);
        check("rst_cpu_rst_n", 64'(bif.cpu_rst_n), 64'd0);
        check("rst_ready", 64'(bif.src_ready), 64'd0);
        check("rst_busy_done", 64'({bif.busy, bif.done, bif.err}), 64'd0);
        check("rst_addr_data", 64'({bif.boot_addr, bif.boot_datai}), 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_ready", 64'(bif.src_ready), 64'd0);

        // Basic back-to-back load, addr = data = k.
        do_start();
        load_words(0, 0, SIZE, cyc);
        check("b2b_cycles", 64'(cyc), 64'(SIZE));
        finish_image(1'b1);

        // Restart from RUN with a throttled source.
        do_start();
        load_words(1, 2, SIZE, cyc);
        check("toggle_cycles", 64'(cyc), 64'(2 * SIZE - 1));
        finish_image(1'b1);

        // Random throttling with start pulses that must be ignored during LOAD.
        do_start();
        load_words(2, 2, SIZE, cyc);
        finish_image(1'b1);

        // Reset asserted while a write is on the port.
        do_start();
        load_words(0, 2, 11, cyc);
        bif.src_valid = 1'b0;
        #1 rst = 1'b1;
        #1;
        check("midrst_boot_up", 64'(bif.boot_up), 64'd0);
        check("midrst_web", 64'(bif.boot_web), 64'd1);
        check("midrst_cpu_rst_n", 64'(bif.cpu_rst_n), 64'd0);
        check("midrst_status", 64'({bif.busy, bif.done, bif.src_ready}), 64'd0);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_idle", 64'({bif.src_ready, bif.busy, bif.boot_up}), 64'd0);
        do_start();
        load_words(0, 1, SIZE, cyc);
        finish_image(1'b1);

`ifdef BOOT_CSUM_EN
        // Bad checksum, then start must clear err and reload cleanly.
        do_start();
        load_words(0, 1, SIZE, cyc);
        finish_image(1'b0);
        do_start();
        load_words(2, 2, SIZE, cyc);
        finish_image(1'b1);
`endif

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
